// File: rtl/sram_lsu_bridge.sv
// Load/store bridge from the RV32 LSU to the IS61WV25616 SRAM controller: one word-aligned
// strobe per access, core stalled until ACK, load lanes extracted and extended on return.
module sram_lsu_bridge #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_lsu_sel,
    input  logic        i_lsu_rden,
    input  logic        i_lsu_wren,
    input  logic [2:0]  i_lsu_funct3,
    input  logic [31:0] i_lsu_addr,
    input  logic [31:0] i_lsu_wdata,
    output logic [31:0] o_lsu_rdata,
    output logic        o_lsu_stall,
    output logic        o_lsu_err,
    output logic [17:0] o_ADDR,
    output logic [31:0] o_WDATA,
    output logic [3:0]  o_BMASK,
    output logic        o_WREN,
    output logic        o_RDEN,
    input  logic [31:0] i_RDATA,
    input  logic        i_ACK
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] b);
        logic [3:0] m;
        case (f3)
            F3_B:    m = 4'b0001 << b;
            F3_H:    m = b[1] ? 4'b1100 : 4'b0011;
            F3_W:    m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Sub-word stores are replicated across lanes so the byte mask alone selects the target.
    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] d;
        case (f3)
            F3_B:    d = {4{wd[7:0]}};
            F3_H:    d = {2{wd[15:0]}};
            F3_W:    d = wd;
            default: d = 32'h0000_0000;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] b,
                                                input logic [31:0] rd);
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        logic [31:0] r;
        case (b)
            2'd0:    lane_b = rd[7:0];
            2'd1:    lane_b = rd[15:8];
            2'd2:    lane_b = rd[23:16];
            default: lane_b = rd[31:24];
        endcase
        lane_h = b[1] ? rd[31:16] : rd[15:0];
        case (f3)
            F3_B:    r = {{24{lane_b[7]}}, lane_b};
            F3_H:    r = {{16{lane_h[15]}}, lane_h};
            F3_W:    r = rd;
            F3_BU:   r = {24'h00_0000, lane_b};
            F3_HU:   r = {16'h0000, lane_h};
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             load_r;
    logic [2:0]       f3_r;
    logic [1:0]       off_r;

    logic req_s;
    logic legal_s;
    logic misalign_s;
    logic go_s;
    logic bad_s;
    logic timeout_s;
    logic stall_s;
    logic err_s;
    logic unused_addr_s;

    assign req_s         = i_lsu_sel & (i_lsu_rden ^ i_lsu_wren);
    assign unused_addr_s = ^i_lsu_addr[31:19];

    // Decode funct3 legality and natural alignment of the presented request.
    always_comb begin
        legal_s    = 1'b0;
        misalign_s = 1'b0;
        if (i_lsu_rden) begin
            case (i_lsu_funct3)
                F3_B, F3_H, F3_W, F3_BU, F3_HU: legal_s = 1'b1;
                default:                        legal_s = 1'b0;
            endcase
        end else begin
            case (i_lsu_funct3)
                F3_B, F3_H, F3_W: legal_s = 1'b1;
                default:          legal_s = 1'b0;
            endcase
        end
        case (i_lsu_funct3)
            F3_H, F3_HU: misalign_s = i_lsu_addr[0];
            F3_W:        misalign_s = (i_lsu_addr[1:0] != 2'b00);
            default:     misalign_s = 1'b0;
        endcase
    end

    assign go_s      = req_s & legal_s & ~misalign_s;
    assign bad_s     = req_s & ~(legal_s & ~misalign_s);
    assign timeout_s = (state_r == ST_WAIT) & ~i_ACK & (cnt_r == CNT_LAST);

    // Core-side handshake; errors must reach the core in the cycle they are detected.
    always_comb begin
        stall_s = 1'b0;
        err_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                stall_s = go_s;
                err_s   = bad_s;
            end
            ST_ISSUE: begin
                stall_s = 1'b1;
                err_s   = 1'b0;
            end
            ST_WAIT: begin
                stall_s = 1'b1;
                err_s   = timeout_s;
            end
            default: begin
                stall_s = 1'b0;
                err_s   = 1'b0;
            end
        endcase
    end

    assign o_lsu_stall = i_reset & stall_s;
    assign o_lsu_err   = i_reset & err_s;

    // Transaction FSM; strobes and load data default low so each is a one-cycle pulse.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            load_r      <= 1'b0;
            f3_r        <= 3'b000;
            off_r       <= 2'b00;
            o_ADDR      <= 18'h0_0000;
            o_WDATA     <= 32'h0000_0000;
            o_BMASK     <= 4'b0000;
            o_WREN      <= 1'b0;
            o_RDEN      <= 1'b0;
            o_lsu_rdata <= 32'h0000_0000;
        end else begin
            o_WREN      <= 1'b0;
            o_RDEN      <= 1'b0;
            o_lsu_rdata <= 32'h0000_0000;
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= '0;
                    if (go_s) begin
                        load_r  <= i_lsu_rden;
                        f3_r    <= i_lsu_funct3;
                        off_r   <= i_lsu_addr[1:0];
                        o_ADDR  <= {i_lsu_addr[18:2], 1'b0};
                        o_BMASK <= i_lsu_rden ? 4'b1111
                                              : store_mask(i_lsu_funct3, i_lsu_addr[1:0]);
                        o_WDATA <= i_lsu_rden ? 32'h0000_0000
                                              : store_data(i_lsu_funct3, i_lsu_wdata);
                        o_WREN  <= i_lsu_wren;
                        o_RDEN  <= i_lsu_rden;
                        state_r <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cnt_r   <= '0;
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_ACK) begin
                        if (load_r) begin
                            o_lsu_rdata <= load_extend(f3_r, off_r, i_RDATA);
                        end
                        cnt_r   <= '0;
                        state_r <= ST_DONE;
                    end else if (cnt_r == CNT_LAST) begin
                        cnt_r   <= '0;
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    cnt_r   <= '0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    cnt_r   <= '0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
